// File: rtl/sdr_pkg.sv
// Shared SDRAM definitions: command encodings, address widths, default timing
// and the in-burst column increment used for read tags.
package sdr_pkg;

    localparam logic [2:0] CMD_NOP       = 3'b111;
    localparam logic [2:0] CMD_ACTIVE    = 3'b011;
    localparam logic [2:0] CMD_READ      = 3'b101;
    localparam logic [2:0] CMD_WRITE     = 3'b100;
    localparam logic [2:0] CMD_PRECHARGE = 3'b010;

    localparam int BA_W  = 2;
    localparam int ROW_W = 13;
    localparam int COL_W = 9;
    localparam int TAG_W = BA_W + COL_W;

    localparam int DEF_CAS_LAT   = 3;
    localparam int DEF_BURST_LEN = 4;

    typedef logic [TAG_W-1:0] rd_tag_t;

    // SDRAM bursts wrap the low column bits inside the burst-aligned window.
    function automatic logic [COL_W-1:0] col_wrap_inc(input logic [COL_W-1:0] col,
                                                      input int burst_len);
        logic [COL_W-1:0] mask;
        mask = COL_W'(burst_len - 1);
        return (col & ~mask) | ((col + COL_W'(1)) & mask);
    endfunction

endpackage

// File: rtl/sdr_rd_capture_if.sv
// Snooped SDRAM command/DQ bus plus the user-side read-data handshake.
// rd_tag exists only when SDR_RD_CAPTURE_TAG_EN is defined.
interface sdr_rd_capture_if #(parameter int DW = 16) ();
    import sdr_pkg::*;

    logic             sdr_nCS;
    logic             sdr_nRAS;
    logic             sdr_nCAS;
    logic             sdr_nWE;
    logic [BA_W-1:0]  sdr_BA;
    logic [ROW_W-1:0] sdr_A;
    logic [DW-1:0]    sdr_DQ_in;

    logic [DW-1:0]    rd_data;
    logic             rd_valid;
    logic             rd_last;
    logic             rd_ready;
    logic             rd_busy;
    logic             rd_ovf;
`ifdef SDR_RD_CAPTURE_TAG_EN
    rd_tag_t          rd_tag;

    modport master (output sdr_nCS, sdr_nRAS, sdr_nCAS, sdr_nWE, sdr_BA, sdr_A, sdr_DQ_in,
                    output rd_ready,
                    input  rd_data, rd_valid, rd_last, rd_busy, rd_ovf, rd_tag);
    modport slave  (input  sdr_nCS, sdr_nRAS, sdr_nCAS, sdr_nWE, sdr_BA, sdr_A, sdr_DQ_in,
                    input  rd_ready,
                    output rd_data, rd_valid, rd_last, rd_busy, rd_ovf, rd_tag);
`else
    modport master (output sdr_nCS, sdr_nRAS, sdr_nCAS, sdr_nWE, sdr_BA, sdr_A, sdr_DQ_in,
                    output rd_ready,
                    input  rd_data, rd_valid, rd_last, rd_busy, rd_ovf);
    modport slave  (input  sdr_nCS, sdr_nRAS, sdr_nCAS, sdr_nWE, sdr_BA, sdr_A, sdr_DQ_in,
                    input  rd_ready,
                    output rd_data, rd_valid, rd_last, rd_busy, rd_ovf);
`endif

endinterface

// File: rtl/sdr_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is accepted only
// when a pop happens on the same edge.
module sdr_sync_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         wr_en;
    logic         rd_en;

    // The extra pointer bit separates full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sdr_rd_capture.sv
// SDRAM read-data capture: snoops READ commands, samples DQ after CAS latency
// and queues words with a last marker. Optional rd_tag via SDR_RD_CAPTURE_TAG_EN.
module sdr_rd_capture import sdr_pkg::*; #(
    parameter int CAS_LAT    = DEF_CAS_LAT,
    parameter int IN_DLY     = 0,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int FIFO_DEPTH = 16,
    parameter int DW         = 16
) (
    input  logic             clk,
    input  logic             rst,
    sdr_rd_capture_if.slave  bus
);

    localparam int L  = CAS_LAT + IN_DLY;
    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
`ifdef SDR_RD_CAPTURE_TAG_EN
    localparam int EW = DW + 1 + TAG_W;
`else
    localparam int EW = DW + 1;
`endif

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CAP  = 1'b1;

    logic          read_det;
    logic [L-1:0]  pipe;
    logic          pipe_out;
    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic          cap_en;
    logic          cap_last;
    logic [EW-1:0] push_word;
    logic [EW-1:0] head_word;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          ovf_q;

    assign read_det = !bus.sdr_nCS && ({bus.sdr_nRAS, bus.sdr_nCAS, bus.sdr_nWE} == CMD_READ);
    assign pipe_out = pipe[L-1];

    always_ff @(posedge clk) begin
        if (rst) pipe <= '0;
        else     pipe <= {pipe[L-2:0], read_det};
    end

    // A pipeline hit captures word 0 on the same edge, so it overrides (truncates)
    // whatever burst is in progress; cnt counts words still owed after this edge.
    assign cap_en   = pipe_out || (state == S_CAP);
    assign cap_last = pipe_out ? (BURST_LEN == 1) : (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else if (pipe_out) begin
            if (BURST_LEN > 1) begin
                state <= S_CAP;
                cnt   <= CW'(BURST_LEN - 2);
            end else begin
                state <= S_IDLE;
            end
        end else if (state == S_CAP) begin
            if (cnt == '0) state <= S_IDLE;
            else           cnt   <= cnt - CW'(1);
        end
    end

`ifdef SDR_RD_CAPTURE_TAG_EN
    rd_tag_t tag_pipe [L];
    rd_tag_t burst_tag;
    rd_tag_t cur_tag;
    logic    unused_row_bits;

    assign unused_row_bits = ^bus.sdr_A[ROW_W-1:COL_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < L; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= {bus.sdr_BA, bus.sdr_A[COL_W-1:0]};
            for (int i = 1; i < L; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign cur_tag = pipe_out ? tag_pipe[L-1] : burst_tag;

    always_ff @(posedge clk) begin
        if (rst)         burst_tag <= '0;
        else if (cap_en) burst_tag <= {cur_tag[TAG_W-1:COL_W],
                                       col_wrap_inc(cur_tag[COL_W-1:0], BURST_LEN)};
    end

    assign push_word  = {cur_tag, cap_last, bus.sdr_DQ_in};
    assign bus.rd_tag = bus.rd_valid ? head_word[EW-1 -: TAG_W] : '0;
`else
    logic unused_addr_bits;

    assign unused_addr_bits = ^{bus.sdr_BA, bus.sdr_A};
    assign push_word        = {cap_last, bus.sdr_DQ_in};
`endif

    sdr_sync_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cap_en),
        .din   (push_word),
        .pop   (pop),
        .dout  (head_word),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign pop = bus.rd_valid && bus.rd_ready;

    always_ff @(posedge clk) begin
        if (rst)                              ovf_q <= 1'b0;
        else if (cap_en && fifo_full && !pop) ovf_q <= 1'b1;
    end

    // Outputs read as zero while empty so an idle bus never shows stale memory.
    assign bus.rd_valid = !fifo_empty;
    assign bus.rd_data  = bus.rd_valid ? head_word[DW-1:0] : '0;
    assign bus.rd_last  = bus.rd_valid && head_word[DW];
    assign bus.rd_busy  = (|pipe) || (state == S_CAP);
    assign bus.rd_ovf   = ovf_q;

endmodule

// File: tb/tb_sdr_rd_capture.sv
// Scoreboard bench for sdr_rd_capture: a cycle-indexed burst schedule and FIFO
// occupancy model predict every word, rd_valid, rd_busy and rd_ovf.
module tb_sdr_rd_capture;
    import sdr_pkg::*;

    localparam int CAS_LAT    = 3;
    localparam int IN_DLY     = 0;
    localparam int BURST_LEN  = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int DW         = 16;
    localparam int L          = CAS_LAT + IN_DLY;
    localparam int MAXC       = 4000;

    typedef struct {
        logic [DW-1:0]    data;
        logic             last;
        logic [TAG_W-1:0] tag;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sdr_rd_capture_if #(.DW(DW)) bus ();

    sdr_rd_capture #(
        .CAS_LAT    (CAS_LAT),
        .IN_DLY     (IN_DLY),
        .BURST_LEN  (BURST_LEN),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DW         (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #3 clk = ~clk;

    word_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;

    // Burst schedule: which burst word (if any) is due at each edge.
    bit               read_at   [MAXC];
    bit               slot_v    [MAXC];
    int               slot_k    [MAXC];
    logic [TAG_W-1:0] slot_base [MAXC];
    int               last_rst_edge = -100;

    int model_occ = 0;
    bit model_ovf = 1'b0;
    bit mon_en    = 1'b0;
    bit occ_now   = 1'b0;
    bit ovf_now   = 1'b0;
    bit busy_now  = 1'b0;
    bit rst_now   = 1'b0;

    // A READ keeps the block busy from its command edge until the edge before its last word.
    function automatic bit busy_after(input int e);
        for (int t = e - (L + BURST_LEN - 2); t <= e; t++)
            if (t >= 0 && t > last_rst_edge && read_at[t]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [TAG_W-1:0] word_tag(input logic [TAG_W-1:0] base, input int k);
        logic [COL_W-1:0] m;
        logic [COL_W-1:0] col;
        m   = COL_W'(BURST_LEN - 1);
        col = base[COL_W-1:0];
        return {base[TAG_W-1:COL_W], (col & ~m) | ((col + COL_W'(k)) & m)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Drives the inputs for edge cyc and advances the model across that edge.
    task automatic applyStimulus(input bit do_read, input bit ready, input bit do_rst);
        logic [2:0]       others [4];
        logic [DW-1:0]    dq;
        logic [TAG_W-1:0] base;
        bit               pop;
        word_t            w;
        others = '{CMD_NOP, CMD_ACTIVE, CMD_WRITE, CMD_PRECHARGE};

        occ_now  = (model_occ > 0);
        ovf_now  = model_ovf;
        busy_now = busy_after(cyc - 1);

        dq             = DW'($urandom);
        rst            = do_rst;
        bus.rd_ready   = ready;
        bus.sdr_DQ_in  = dq;
        bus.sdr_BA     = BA_W'($urandom);
        bus.sdr_A      = ROW_W'($urandom);
        if (do_read) begin
            bus.sdr_nCS = 1'b0;
            {bus.sdr_nRAS, bus.sdr_nCAS, bus.sdr_nWE} = CMD_READ;
        end else if ($urandom_range(0, 2) == 0) begin
            bus.sdr_nCS = 1'b1;
            {bus.sdr_nRAS, bus.sdr_nCAS, bus.sdr_nWE} = CMD_READ;
        end else begin
            bus.sdr_nCS = 1'b0;
            {bus.sdr_nRAS, bus.sdr_nCAS, bus.sdr_nWE} = others[$urandom_range(0, 3)];
        end

        if (do_rst) begin
            model_occ = 0;
            model_ovf = 1'b0;
            exp_q.delete();
            for (int t = cyc; t < MAXC; t++) slot_v[t] = 1'b0;
            last_rst_edge = cyc;
        end else begin
            if (do_read) begin
                read_at[cyc] = 1'b1;
                base = {bus.sdr_BA, bus.sdr_A[COL_W-1:0]};
                for (int k = 0; k < BURST_LEN; k++) begin
                    slot_v[cyc+L+k]    = 1'b1;
                    slot_k[cyc+L+k]    = k;
                    slot_base[cyc+L+k] = base;
                end
            end
            pop = (model_occ > 0) && ready;
            if (slot_v[cyc]) begin
                w.data = dq;
                w.last = (slot_k[cyc] == BURST_LEN - 1);
                w.tag  = word_tag(slot_base[cyc], slot_k[cyc]);
                if (model_occ < FIFO_DEPTH || pop) begin
                    exp_q.push_back(w);
                    model_occ++;
                end else begin
                    model_ovf = 1'b1;
                end
            end
            if (pop) model_occ--;
        end

        @(posedge clk);
        #1;
        rst_now = do_rst;
        cyc++;
    endtask

    // Monitor: checks status every cycle and pops the scoreboard on each handshake.
    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                checkOutput("rd_valid", 32'(bus.rd_valid), 32'(occ_now));
                checkOutput("rd_busy",  32'(bus.rd_busy),  32'(busy_now));
                checkOutput("rd_ovf",   32'(bus.rd_ovf),   32'(ovf_now));
                if (rst_now) begin
                    checkOutput("rd_data_after_rst", 32'(bus.rd_data), 32'd0);
                    checkOutput("rd_last_after_rst", 32'(bus.rd_last), 32'd0);
                end
                if (bus.rd_valid && bus.rd_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("spurious_word", 32'(bus.rd_data), 32'hDEAD_0000);
                    end else begin
                        w = exp_q.pop_front();
                        checkOutput("rd_data", 32'(bus.rd_data), 32'(w.data));
                        checkOutput("rd_last", 32'(bus.rd_last), 32'(w.last));
`ifdef SDR_RD_CAPTURE_TAG_EN
                        checkOutput("rd_tag", 32'(bus.rd_tag), 32'(w.tag));
`endif
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        bus.rd_ready  = 1'b0;
        bus.sdr_nCS   = 1'b1;
        bus.sdr_nRAS  = 1'b1;
        bus.sdr_nCAS  = 1'b1;
        bus.sdr_nWE   = 1'b1;
        bus.sdr_BA    = '0;
        bus.sdr_A     = '0;
        bus.sdr_DQ_in = '0;

        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);
        mon_en = 1'b1;
        $display("[TB] reset done, starting directed bursts");

        // Single READ
        applyStimulus(1, 1, 0);
        repeat (12) applyStimulus(0, 1, 0);

        // Back-to-back READs four cycles apart
        applyStimulus(1, 1, 0);
        repeat (3) applyStimulus(0, 1, 0);
        applyStimulus(1, 1, 0);
        repeat (12) applyStimulus(0, 1, 0);

        // Truncation: second READ two cycles after the first
        applyStimulus(1, 1, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(1, 1, 0);
        repeat (12) applyStimulus(0, 1, 0);

        // Fill to full with rd_ready low, then keep capturing while popping
        for (int s = 0; s < 40; s++)
            applyStimulus((s % 4 == 0) && (s < 32), (s >= 19), 0);
        repeat (20) applyStimulus(0, 1, 0);

        // Reset on the second word of a burst, then a clean READ
        applyStimulus(1, 1, 0);
        repeat (3) applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 1);
        applyStimulus(1, 1, 0);
        repeat (12) applyStimulus(0, 1, 0);

        $display("[TB] random traffic");
        repeat (300) applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0, 0);
        repeat (30) applyStimulus(0, 1, 0);

        // Backpressure: five bursts into a 16-deep FIFO with rd_ready low
        for (int s = 0; s < 24; s++)
            applyStimulus((s % 4 == 0) && (s < 20), 0, 0);
        repeat (30) applyStimulus(0, 1, 0);

        // Random traffic on top of the sticky overflow, then reset and more traffic
        repeat (150) applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 0);
        applyStimulus(0, 0, 1);
        repeat (150) applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0, 0);

        guard = 0;
        while ((exp_q.size() != 0 || busy_after(cyc - 1)) && guard < 200) begin
            applyStimulus(0, 1, 0);
            guard++;
        end
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sdr_rd_capture.md
Name: sdr_rd_capture

Overview:
- Read-data capture stage directly downstream of the SDRAM read command generator.
- Snoops the registered SDRAM command bus. On each READ command it waits CAS latency, samples BURST_LEN words from the DQ input and pushes them into a small FIFO.
- Presents the words to the user side with a valid/ready handshake and a last-of-burst marker.

Parameters:
- CAS_LAT, 3, CAS latency in clk cycles; legal values 2 or 3.
- IN_DLY, 0, extra capture delay for board/IO registering; legal range 0..2.
- BURST_LEN, 4, words per READ; legal values 1, 2, 4 or 8; must match the mode register.
- FIFO_DEPTH, 16, capture FIFO entries; power of two, at least 2*BURST_LEN.
- DW, 16, data width.

Ports:
- clk  in  1  clock, 167MHz, shared with the SDRAM command path
- rst  in  1  synchronous reset, active-high
- sdr_nCS  in  1  snooped chip select
- sdr_nRAS  in  1  snooped RAS
- sdr_nCAS  in  1  snooped CAS
- sdr_nWE  in  1  snooped WE
- sdr_BA  in  2  snooped bank address
- sdr_A  in  13  snooped address; bits [8:0] are the column
- sdr_DQ_in  in  DW  DQ input half of the pad
- rd_data  out  DW  head-of-FIFO data
- rd_valid  out  1  rd_data valid
- rd_last  out  1  rd_data is the final word of its burst
- rd_ready  in  1  consumer accepts the word
- rd_busy  out  1  a READ is in flight or a burst is being captured
- rd_ovf  out  1  sticky: a captured word was dropped because the FIFO was full

Behaviour:
- Clock and reset:
  - One clock: clk. Reset rst is synchronous, active-high.
  - rst clears the pipeline, burst counter, FIFO pointers and rd_ovf.
  - After reset: rd_valid=0, rd_last=0, rd_busy=0, rd_ovf=0, rd_data=0.
  - Reset mid-burst discards all in-flight and buffered data.
- READ detect:
  - A READ is detected at edge T when {nCS,nRAS,nCAS,nWE}=4'b0101 (nCS=0, then CMD_READ=3'b101).
  - ACTIVE, PRECHARGE, NOP and WRITE commands are ignored.
- Latency pipeline:
  - A shift register of length L=CAS_LAT+IN_DLY carries a 1 for each detected READ.
  - When the bit exits at edge T+L, the burst counter loads BURST_LEN-1 and capture begins.
  - Word k (k=0..BURST_LEN-1) is sampled from sdr_DQ_in at edge T+L+k.
- Capture states:
  - IDLE to CAP when the pipeline output is 1.
  - CAP to IDLE after word BURST_LEN-1 is sampled, unless the pipeline output is 1 at that same edge; in that case stay in CAP and reload the counter (seamless back-to-back bursts).
- Truncation:
  - If the pipeline output is 1 while the counter is non-zero, the SDRAM has truncated the previous burst.
  - The counter reloads. The truncated burst carries no rd_last; the new burst captures normally.
- rd_last is stored in the FIFO alongside the word captured when the counter equals 0.
- FIFO:
  - Synchronous, first-word-fall-through.
  - Push each captured word; pop on rd_valid & rd_ready.
  - Push and pop in the same cycle are both honoured, even when full.
  - Push when full and no pop: the word is dropped and rd_ovf is set; rd_ovf stays set until rst.
  - rd_valid = FIFO not empty. rd_data and rd_last hold stable while rd_valid=1 and rd_ready=0.
- rd_busy = (pipeline bits non-zero) | (state == CAP).
- Pointers are log2(FIFO_DEPTH)+1 bits wide so full and empty are distinguishable; they wrap modulo 2*FIFO_DEPTH.

Optional Feature:
- Macro: SDR_RD_CAPTURE_TAG_EN.
- With the macro defined:
  - Adds output rd_tag, 11 bits, = {BA, column[8:0]} latched when the READ is detected.
  - The tag travels through the latency pipeline alongside the READ bit.
  - It is stored with each FIFO word and incremented by 1 per word within the burst, with column wrap inside the burst boundary.
- Without the macro: no rd_tag port, and the FIFO entry is DW+1 bits.

Decomposition:
- Shared package sdr_pkg:
  - Command encodings CMD_NOP=3'b111, CMD_ACTIVE=3'b011, CMD_READ=3'b101, CMD_WRITE=3'b100, CMD_PRECHARGE=3'b010.
  - Address widths: BA 2, row 13, column 9.
  - The default CAS_LAT and BURST_LEN values.
- Sub-module sdr_sync_fifo: parameterised width and depth, FWFT, full/empty outputs. sdr_rd_capture instantiates it once.

Test Plan:
- Single READ, CAS_LAT=3, IN_DLY=0, BURST_LEN=4, command at edge 10, DQ driving 0xA000..0xA003 at edges 13..16, rd_ready=1 -> rd_data A000..A003 presented in order, rd_last only on A003, rd_busy high from edge 10 through 16.
- Back-to-back READs at edges 10 and 14 -> 8 contiguous words; rd_last on words 4 and 8; capture never returns to IDLE between bursts.
- Truncation: READs at edges 10 and 12 -> 2 words from the first burst (no rd_last), then 4 words from the second, rd_last on the final word; 6 words total.
- Backpressure: rd_ready=0 while 5 READs complete (20 words, FIFO_DEPTH=16) -> 16 words retained, rd_ovf=1 at the 17th capture edge; rd_ovf stays 1 after draining; the 16 retained words are the first 16 in order.
- Simultaneous push/pop with FIFO full and rd_ready=1 -> no drop, occupancy stays 16, rd_ovf stays 0.
- rst asserted at the second word of a burst -> the next edge shows rd_valid=0, rd_busy=0, rd_ovf=0; a subsequent READ captures cleanly.
